// File: rtl/iter_fixed_point_sqrt.sv
// Iterative signed fixed-point square root.
// Restoring digit-by-digit: resolves BPC root bits per cycle, MSB first, then
// resizes the WRI.WIF magnitude to WOI.WOF with optional rounding and saturation.
// One operation in flight; valid/ready handshake on both sides.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | i_ready=1, waiting for an operand
// CALC   | resolving root bits, BPC per cycle, cnt counts down from C
// RESIZE | one cycle: round, reapply sign, saturate, register result
// DONE   | o_valid=1, result held until o_ready
module iter_fixed_point_sqrt #(
   parameter int WII      = 8,
   parameter int WIF      = 8,
   parameter int WOI      = 8,
   parameter int WOF      = 8,
   parameter int ROUND    = 1,
   parameter int BPC      = 1,
   parameter int NEG_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [WII+WIF-1:0]   in,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [WOI+WOF-1:0]   out,
   output logic                 overflow,
   output logic                 neg_err
);

   // Integer part widened to an even bit count so root bits pair with radicand bit pairs.
   localparam int WTI = WII + (WII % 2);
   localparam int WRI = WTI / 2;
   localparam int N   = WRI + WIF;
   localparam int C   = (N + BPC - 1) / BPC;
   localparam int WM  = WTI + WIF;
   // Radicand carries WIF extra fraction bits so the integer root has WIF fraction bits.
   localparam int WQ  = 2 * N;
   localparam int WO  = WOI + WOF;
   localparam int CW  = $clog2(C + 1);
   localparam int RW  = $clog2(N + 1);
   localparam int SHL = (WOF >= WIF) ? (WOF - WIF) : 0;
   localparam int SHR = (WIF > WOF) ? (WIF - WOF) : 0;
   localparam int RND = (ROUND != 0 && SHR > 0) ? (1 << ((SHR > 0) ? SHR - 1 : 0)) : 0;
   localparam int WX  = (((N + SHL) > WO) ? (N + SHL) : WO) + 2;

   typedef enum logic [1:0] {IDLE, CALC, RESIZE, DONE} state_t;

   state_t          state;
   logic            sign_q;
   logic            neg_q;
   logic [WQ-1:0]   rad;
   logic [N-1:0]    root;
   logic [WQ-1:0]   sq;
   logic [CW-1:0]   cnt;
   logic [RW-1:0]   rem;

   logic [WM-1:0]   in_sx;
   logic [WM-1:0]   mag;

   logic [N-1:0]    root_n;
   logic [WQ-1:0]   sq_n;
   logic [WQ-1:0]   trial;
   logic [RW-1:0]   rem_n;

   logic [WX-1:0]   mag_w;
   logic [WX-1:0]   mag_o;
   logic [WX-1:0]   lim_pos;
   logic [WX-1:0]   lim_neg;
   logic [WO-1:0]   res;
   logic            ovf;
   logic            neg;

   // Magnitude of the operand; the widened width keeps the most negative value from wrapping.
   assign in_sx = WM'($signed(in));
   assign mag   = in[WII+WIF-1] ? (WM'(0) - in_sx) : in_sx;

   // One CALC cycle: test up to BPC bits, MSB first; rem is the count of untested bits.
   always_comb begin
      root_n = root;
      sq_n   = sq;
      rem_n  = rem;
      trial  = '0;
      for (int k = 0; k < BPC; k++) begin
         if (rem_n != '0) begin
            trial = sq_n + (WQ'(root_n) << rem_n) + (WQ'(1) << (2 * (int'(rem_n) - 1)));
            if (rad != '0 && trial <= rad) begin
               root_n = root_n | (N'(1) << (rem_n - RW'(1)));
               sq_n   = trial;
            end
            rem_n = rem_n - RW'(1);
         end
      end
   end

   // Resize magnitude to the output format, round, reapply sign, saturate.
   always_comb begin
      mag_w   = WX'(root);
      mag_o   = ((mag_w << SHL) + WX'(RND)) >> SHR;
      lim_neg = WX'(1) << (WO - 1);
      lim_pos = lim_neg - WX'(1);
      neg     = sign_q && (NEG_MODE == 0);
      ovf     = 1'b0;
      res     = '0;
      if (neg) begin
         if (mag_o > lim_neg) begin
            res = {1'b1, {(WO-1){1'b0}}};
            ovf = 1'b1;
         end else begin
            res = WO'(WX'(0) - mag_o);
         end
      end else begin
         if (mag_o > lim_pos) begin
            res = {1'b0, {(WO-1){1'b1}}};
            ovf = 1'b1;
         end else begin
            res = WO'(mag_o);
         end
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         i_ready  <= 1'b1;
         o_valid  <= 1'b0;
         out      <= '0;
         overflow <= 1'b0;
         neg_err  <= 1'b0;
         sign_q   <= 1'b0;
         neg_q    <= 1'b0;
         rad      <= '0;
         root     <= '0;
         sq       <= '0;
         cnt      <= '0;
         rem      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  sign_q  <= in[WII+WIF-1];
                  rad     <= {mag, {WIF{1'b0}}};
                  root    <= '0;
                  sq      <= '0;
                  cnt     <= CW'(C);
                  rem     <= RW'(N);
                  i_ready <= 1'b0;
                  // With NEG_MODE set a negative operand has no root; root stays 0.
                  if (NEG_MODE != 0 && in[WII+WIF-1]) begin
                     neg_q <= 1'b1;
                     state <= RESIZE;
                  end else begin
                     neg_q <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               root <= root_n;
               sq   <= sq_n;
               rem  <= rem_n;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= RESIZE;
               end
            end
            RESIZE: begin
               out      <= res;
               overflow <= ovf;
               neg_err  <= neg_q;
               o_valid  <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
